// File: rtl/booth_mul_pkg.sv
// Shared types and constants for the Booth multiplier arbiter.
//   state_t     : scheduler states
//   DEF_W       : default operand width
//   DEF_TIMEOUT : default watchdog limit, in ISSUE cycles
//   id_width()  : requester id width, clog2 with a floor of 1 bit
package booth_mul_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RELEASE = 2'd2,
      HALT    = 2'd3
   } state_t;

   localparam int DEF_W       = 8;
   localparam int DEF_TIMEOUT = 63;

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req        : request levels, one bit per requester
//   last_grant : id granted most recently; search starts at last_grant+1
//   win        : one-hot winner (all zero when req == 0)
//   win_id     : binary id of the winner (0 when req == 0)
module rr_arbiter
   import booth_mul_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]             req,
   input  logic [id_width(NREQ)-1:0]   last_grant,
   output logic [NREQ-1:0]             win,
   output logic [id_width(NREQ)-1:0]   win_id
);

   localparam int IW = id_width(NREQ);

   logic [IW-1:0] cand;

   // Walk from the lowest priority slot to the highest so the last hit,
   // i.e. the one closest after last_grant, is the one that sticks.
   always_comb begin
      win    = '0;
      win_id = '0;
      cand   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = IW'((int'(last_grant) + 1 + i) % NREQ);
         if (req[cand]) begin
            win       = '0;
            win[cand] = 1'b1;
            win_id    = cand;
         end
      end
   end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin scheduler sharing one W x W Booth multiplier among NREQ
// requesters, with a watchdog on the multiplier's done pulse.
//   clk, rst      : clock; asynchronous active-low reset
//   req           : request levels, sampled only in IDLE
//   a_in, b_in    : packed operands, requester k owns [k*W +: W]
//   gnt           : one-cycle one-hot pulse, operands captured
//   resp_valid    : one-cycle pulse, resp_id/resp_product updated
//   resp_id       : requester owning resp_product
//   resp_product  : product, held until the next resp_valid
//   busy          : high in ISSUE and RELEASE
//   err           : sticky watchdog error, only rst clears it
//   mul_start     : level start to the multiplier
//   mul_a, mul_b  : multiplier operands, constant through ISSUE
//   mul_done      : multiplier completion pulse (ignored outside ISSUE)
//   mul_product   : multiplier result
module booth_mul_arbiter
   import booth_mul_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int W       = DEF_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NREQ-1:0]             req,
   input  logic [NREQ*W-1:0]           a_in,
   input  logic [NREQ*W-1:0]           b_in,
   output logic [NREQ-1:0]             gnt,
   output logic                        resp_valid,
   output logic [id_width(NREQ)-1:0]   resp_id,
   output logic [2*W-1:0]              resp_product,
   output logic                        busy,
   output logic                        err,
   output logic                        mul_start,
   output logic [W-1:0]                mul_a,
   output logic [W-1:0]                mul_b,
   input  logic                        mul_done,
   input  logic [2*W-1:0]              mul_product
);

   localparam int IW = id_width(NREQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t        state;
   logic [IW-1:0] last_grant;
   logic [IW-1:0] cur_id;
   logic [CW-1:0] wd;

   logic [NREQ-1:0] win;
   logic [IW-1:0]   win_id;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req        (req),
      .last_grant (last_grant),
      .win        (win),
      .win_id     (win_id)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         last_grant   <= IW'(NREQ - 1);
         cur_id       <= '0;
         wd           <= '0;
         gnt          <= '0;
         resp_valid   <= 1'b0;
         resp_id      <= '0;
         resp_product <= '0;
         busy         <= 1'b0;
         err          <= 1'b0;
         mul_start    <= 1'b0;
         mul_a        <= '0;
         mul_b        <= '0;
      end else begin
         gnt        <= '0;
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt       <= win;
                  cur_id    <= win_id;
                  mul_a     <= a_in[int'(win_id)*W +: W];
                  mul_b     <= b_in[int'(win_id)*W +: W];
                  mul_start <= 1'b1;
                  busy      <= 1'b1;
                  wd        <= '0;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               // done wins over the watchdog if both land on the same cycle
               if (mul_done) begin
                  resp_product <= mul_product;
                  resp_id      <= cur_id;
                  resp_valid   <= 1'b1;
                  mul_start    <= 1'b0;
                  last_grant   <= cur_id;
                  state        <= RELEASE;
               end else if (wd == CW'(TIMEOUT - 1)) begin
                  // this is the TIMEOUT-th ISSUE cycle without done
                  mul_start <= 1'b0;
                  busy      <= 1'b0;
                  err       <= 1'b1;
                  state     <= HALT;
               end else begin
                  wd <= wd + CW'(1);
               end
            end
            RELEASE: begin
               // one cycle with start low lets the multiplier fall back to load
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               // HALT: absorbing until rst
               state <= HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
module tb_booth_mul_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 8;
   localparam int IW   = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*W-1:0] a_in = '0;
   logic [NREQ*W-1:0] b_in = '0;
   logic [NREQ-1:0]   gnt;
   logic              resp_valid;
   logic [IW-1:0]     resp_id;
   logic [2*W-1:0]    resp_product;
   logic              busy, err, mul_start;
   logic [W-1:0]      mul_a, mul_b;
   logic              mul_done;
   logic [2*W-1:0]    mul_product;

   logic        stub = 1'b0;
   logic        spur = 1'b0;
   logic [5:0]  mcnt;
   logic signed [15:0] ea, eb;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [15:0]   p;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   booth_mul_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(63)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .a_in         (a_in),
      .b_in         (b_in),
      .gnt          (gnt),
      .resp_valid   (resp_valid),
      .resp_id      (resp_id),
      .resp_product (resp_product),
      .busy         (busy),
      .err          (err),
      .mul_start    (mul_start),
      .mul_a        (mul_a),
      .mul_b        (mul_b),
      .mul_done     (mul_done),
      .mul_product  (mul_product)
   );

   // Behavioural multiplier: done visible on the 20th cycle after start rises.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                mcnt <= '0;
      else if (!mul_start)     mcnt <= '0;
      else if (mcnt != 6'd63)  mcnt <= mcnt + 6'd1;
   end
   assign mul_done    = (mul_start && mcnt == 6'd20 && !stub) || spur;
   assign ea          = {{8{mul_a[7]}}, mul_a};
   assign eb          = {{8{mul_b[7]}}, mul_b};
   assign mul_product = ea * eb;

   function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
      logic signed [15:0] x, y;
      x = {{8{a[7]}}, a};
      y = {{8{b[7]}}, b};
      return x * y;
   endfunction

   task automatic set_ops(input int k, input logic [7:0] a, input logic [7:0] b);
      a_in[k*W +: W] = a;
      b_in[k*W +: W] = b;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Scoreboard: every response must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst && resp_valid) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_resp id=%0d product=%h", resp_id, resp_product);
         end else begin
            mon_e = sb.pop_front();
            if (resp_id !== mon_e.id || resp_product !== mon_e.p) begin
               miscompares++;
               $display("FAIL sb_resp got id=%0d product=%h want id=%0d product=%h",
                        resp_id, resp_product, mon_e.id, mon_e.p);
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({gnt, resp_valid, busy, err, mul_start} !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_ctrl got gnt=%b rv=%b busy=%b err=%b start=%b",
                  gnt, resp_valid, busy, err, mul_start);
      end
      vectors++;
      if ({resp_id, resp_product, mul_a, mul_b} !== 34'h0) begin
         miscompares++;
         $display("FAIL reset_data got id=%0d prod=%h a=%h b=%h want all 0",
                  resp_id, resp_product, mul_a, mul_b);
      end
      rst = 1'b1;
   endtask

   task automatic test_single();
      int st, rv_cyc;
      @(negedge clk);
      set_ops(0, 8'd3, 8'd5);
      req = 4'b0001;
      sb.push_back({2'd0, 16'd15});
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b0001) begin
         miscompares++; $display("FAIL single_gnt got %b want 0001", gnt);
      end
      vectors++;
      if ({mul_start, busy, mul_a, mul_b} !== {1'b1, 1'b1, 8'd3, 8'd5}) begin
         miscompares++;
         $display("FAIL single_issue got start=%b busy=%b a=%0d b=%0d want 1 1 3 5",
                  mul_start, busy, mul_a, mul_b);
      end
      req = '0;
      st = 1; rv_cyc = 0;
      for (int k = 2; k <= 40; k++) begin
         @(negedge clk);
         if (mul_start) st++;
         if (resp_valid && rv_cyc == 0) rv_cyc = k;
         if (k == 2) begin
            vectors++;
            if (gnt !== 4'b0000) begin
               miscompares++; $display("FAIL gnt_pulse got %b want 0000", gnt);
            end
         end
      end
      vectors++;
      if (rv_cyc != 22) begin
         miscompares++; $display("FAIL single_latency got %0d want 22", rv_cyc);
      end
      vectors++;
      if (st != 21) begin
         miscompares++; $display("FAIL start_len got %0d want 21", st);
      end
   endtask

   task automatic test_contention();
      int ids[4];
      int cyc[4];
      int ng, nr;
      do_reset();
      @(negedge clk);
      set_ops(0, 8'd10, 8'd11);
      set_ops(1, 8'd12, 8'd13);
      set_ops(3, 8'hF0, 8'd9);
      sb.push_back({2'd0, smul(8'd10, 8'd11)});
      sb.push_back({2'd1, smul(8'd12, 8'd13)});
      sb.push_back({2'd3, smul(8'hF0, 8'd9)});
      req = 4'b1011;
      ng = 0; nr = 0;
      for (int k = 1; k <= 140 && nr < 4; k++) begin
         @(negedge clk);
         if (resp_valid) nr++;
         if (gnt != '0 && ng < 4) begin
            for (int j = 0; j < NREQ; j++) begin
               if (gnt[j]) begin
                  ids[ng] = j;
                  req[j] = 1'b0;
               end
            end
            cyc[ng] = k;
            ng++;
            if (ng == 3) begin
               set_ops(0, 8'd200, 8'd2);
               sb.push_back({2'd0, smul(8'd200, 8'd2)});
               req[0] = 1'b1;
            end
         end
      end
      vectors++;
      if (ng != 4 || nr != 4) begin
         miscompares++; $display("FAIL contention_count got grants=%0d resps=%0d want 4 4", ng, nr);
      end else begin
         vectors++;
         if (ids[0] != 0 || ids[1] != 1 || ids[2] != 3 || ids[3] != 0) begin
            miscompares++;
            $display("FAIL grant_order got %0d,%0d,%0d,%0d want 0,1,3,0", ids[0], ids[1], ids[2], ids[3]);
         end
         for (int g = 1; g < 4; g++) begin
            vectors++;
            if (cyc[g] - cyc[g-1] != 23) begin
               miscompares++;
               $display("FAIL grant_spacing%0d got %0d want 23", g, cyc[g] - cyc[g-1]);
            end
         end
      end
   endtask

   task automatic test_signed();
      bit seen;
      @(negedge clk);
      set_ops(2, 8'hFD, 8'd7);
      req = 4'b0100;
      sb.push_back({2'd2, 16'hFFEB});
      @(negedge clk);
      req = '0;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (resp_valid) seen = 1;
      end
      vectors++;
      if (!seen || resp_product !== 16'hFFEB || resp_id !== 2'd2) begin
         miscompares++;
         $display("FAIL signed got seen=%0d id=%0d product=%h want 1 2 ffeb", seen, resp_id, resp_product);
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (resp_product !== 16'hFFEB) begin
         miscompares++; $display("FAIL product_hold got %h want ffeb", resp_product);
      end
   endtask

   task automatic test_reset_midop();
      bit seen;
      @(negedge clk);
      set_ops(1, 8'd9, 8'd9);
      req = 4'b0010;
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b0010) begin
         miscompares++; $display("FAIL midop_gnt got %b want 0010", gnt);
      end
      req = '0;
      repeat (9) @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if ({mul_start, busy, gnt, mul_a} !== 14'h0) begin
         miscompares++;
         $display("FAIL async_reset got start=%b busy=%b gnt=%b a=%h want 0", mul_start, busy, gnt, mul_a);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      set_ops(2, 8'd6, 8'd7);
      req = 4'b0100;
      sb.push_back({2'd2, 16'd42});
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b0100) begin
         miscompares++; $display("FAIL post_reset_gnt got %b want 0100", gnt);
      end
      req = '0;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (resp_valid) seen = 1;
      end
      vectors++;
      if (!seen) begin
         miscompares++; $display("FAIL post_reset_resp got none want product 42");
      end
   endtask

   task automatic test_spurious_done();
      int bad;
      bit seen;
      repeat (2) @(negedge clk);
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (resp_valid || busy) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++; $display("FAIL spurious_done got %0d active cycles want 0", bad);
      end
      set_ops(3, 8'h7F, 8'h80);
      req = 4'b1000;
      sb.push_back({2'd3, 16'hC080});
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b1000) begin
         miscompares++; $display("FAIL after_spur_gnt got %b want 1000", gnt);
      end
      req = '0;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (resp_valid) seen = 1;
      end
      vectors++;
      if (!seen) begin
         miscompares++; $display("FAIL after_spur_resp got none want c080");
      end
   endtask

   task automatic test_watchdog();
      int st, ec, bad;
      stub = 1'b1;
      @(negedge clk);
      set_ops(0, 8'd1, 8'd1);
      req = 4'b0001;
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b0001) begin
         miscompares++; $display("FAIL wd_gnt got %b want 0001", gnt);
      end
      req = '0;
      st = 1; ec = 0;
      for (int k = 2; k <= 100; k++) begin
         @(negedge clk);
         if (mul_start) st++;
         if (err && ec == 0) ec = k;
      end
      vectors++;
      if (st != 63 || ec != 64 || mul_start !== 1'b0) begin
         miscompares++;
         $display("FAIL watchdog got start_cycles=%0d err_cycle=%0d start=%b want 63 64 0", st, ec, mul_start);
      end
      req = 4'b1111;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (gnt != '0 || busy || !err) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++; $display("FAIL halt_absorb got %0d bad cycles want 0", bad);
      end
      req = '0;
      stub = 1'b0;
      do_reset();
      @(negedge clk);
      vectors++;
      if (err !== 1'b0) begin
         miscompares++; $display("FAIL err_clear got %b want 0", err);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_signed();
      test_reset_midop();
      test_spurious_done();
      test_watchdog();
      repeat (3) @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++; $display("FAIL sb_drain got %0d pending want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
